// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot sequencer and port owner for the rv32im instruction memory
// Optional NOP tail fill: define IMEM_BOOT_LOADER_NOP_FILL_EN.
module imem_boot_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   word_count_i,
  input  logic [31:0]       s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [31:0]       fetch_addr_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
`ifdef IMEM_BOOT_LOADER_NOP_FILL_EN
    ST_FILL = 2'd3,
`endif
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   N_ONE   = (ADDR_W + 1)'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W:0]   n_q;
  logic              core_rst_n_q;
  logic              done_q;
  logic              err_q;

  logic fire;
  logic count_ok;
  logic last_word;
  logic unused_bits;

  // Valid counts are 1..DEPTH: nonzero, and if the top bit is set the rest must be zero.
  assign count_ok  = (word_count_i != '0) &&
                     (!word_count_i[ADDR_W] || (word_count_i[ADDR_W-1:0] == '0));
  assign fire      = s_valid_i && (state_q == ST_LOAD);
  assign last_word = ({1'b0, cnt_q} == (n_q - N_ONE));

`ifdef IMEM_BOOT_LOADER_NOP_FILL_EN
  assign unused_bits = ^{fetch_addr_i[31:ADDR_W+2], fetch_addr_i[1:0]};
`else
  assign unused_bits = ^{fetch_addr_i[31:ADDR_W+2], fetch_addr_i[1:0], NOP_WORD};
`endif

  assign core_rst_n_o = core_rst_n_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

  always_comb begin
    s_ready_o   = 1'b0;
    busy_o      = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      ST_LOAD: begin
        s_ready_o = 1'b1;
        busy_o    = 1'b1;
        if (fire) begin
          mem_we_o    = 1'b1;
          mem_addr_o  = cnt_q;
          mem_wdata_o = s_data_i;
        end
      end
`ifdef IMEM_BOOT_LOADER_NOP_FILL_EN
      ST_FILL: begin
        busy_o      = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = cnt_q;
        mem_wdata_o = NOP_WORD;
      end
`endif
      ST_RUN:  mem_addr_o = fetch_addr_i[ADDR_W+1:2];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      n_q          <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (count_ok) begin
              n_q     <= word_count_i;
              cnt_q   <= '0;
              err_q   <= 1'b0;
              state_q <= ST_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (fire) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (last_word) begin
`ifdef IMEM_BOOT_LOADER_NOP_FILL_EN
              if (!n_q[ADDR_W]) begin
                state_q <= ST_FILL;
              end else begin
                cnt_q        <= '0;
                core_rst_n_q <= 1'b1;
                done_q       <= 1'b1;
                state_q      <= ST_RUN;
              end
`else
              cnt_q        <= '0;
              core_rst_n_q <= 1'b1;
              done_q       <= 1'b1;
              state_q      <= ST_RUN;
`endif
            end
          end
        end
`ifdef IMEM_BOOT_LOADER_NOP_FILL_EN
        ST_FILL: begin
          // cnt wraps to 0 on the final write at DEPTH-1.
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == '1) begin
            core_rst_n_q <= 1'b1;
            done_q       <= 1'b1;
            state_q      <= ST_RUN;
          end
        end
`endif
        ST_RUN: begin
          if (start_i) begin
            if (count_ok) begin
              n_q          <= word_count_i;
              cnt_q        <= '0;
              err_q        <= 1'b0;
              core_rst_n_q <= 1'b0;
              done_q       <= 1'b0;
              state_q      <= ST_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized self-checking bench for imem_boot_loader
// Expectations follow IMEM_BOOT_LOADER_NOP_FILL_EN when it is defined.
module tb_imem_boot_loader;

  localparam int          ADDR_W = 4;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clk          = 1'b0;
  logic              rst_n        = 1'b1;
  logic              start_i      = 1'b0;
  logic [ADDR_W:0]   word_count_i = '0;
  logic [31:0]       s_data_i     = '0;
  logic              s_valid_i    = 1'b0;
  logic [31:0]       fetch_addr_i = '0;
  logic              s_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              core_rst_n_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] words   [DEPTH];
  logic [31:0] ref_mem [DEPTH] = '{default: 32'hDEAD_BEEF};
  logic [31:0] dut_mem [DEPTH] = '{default: 32'hDEAD_BEEF};

  imem_boot_loader #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .word_count_i (word_count_i),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .fetch_addr_i (fetch_addr_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_rst_n_o (core_rst_n_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we_o) dut_mem[mem_addr_o] <= mem_wdata_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_core_rst_n", core_rst_n_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_s_ready", s_ready_o, 0);
    check("rst_we", mem_we_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
  endtask

  // Rejected start: err rises next cycle, core/state untouched.
  task automatic reject(input int count, input bit in_run);
    start_i      = 1'b1;
    word_count_i = (ADDR_W + 1)'(count);
    @(posedge clk); #1;
    start_i = 1'b0;
    #1;
    check("rej_err", err_o, 1);
    check("rej_core_rst_n", core_rst_n_o, in_run);
    check("rej_done", done_o, in_run);
    check("rej_busy", busy_o, 0);
    @(posedge clk); #2;
    check("rej_err_hold", err_o, 1);
  endtask

  task automatic load(input int n, input int gap_pct, input int abort_after, input bit poke);
    int k   = 0;
    int cyc = 0;
    start_i      = 1'b1;
    word_count_i = (ADDR_W + 1)'(n);
    s_valid_i    = 1'b0;
    #1;
    check("pre_busy", busy_o, 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    #1;
    check("load_core_rst_n", core_rst_n_o, 0);
    check("load_done", done_o, 0);
    check("load_err_clr", err_o, 0);
    while (k < n) begin
      if (cyc > 200) begin
        check("load_timeout", k, n);
        break;
      end
      if (k == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        s_valid_i = 1'b0;
        return;
      end
      s_valid_i = ($urandom_range(0, 99) >= gap_pct);
      s_data_i  = words[k];
      if (poke) begin
        start_i      = 1'($urandom_range(0, 1));
        word_count_i = (ADDR_W + 1)'($urandom_range(1, DEPTH));
      end
      #1;
      check("load_s_ready", s_ready_o, 1);
      check("load_busy", busy_o, 1);
      check("load_we", mem_we_o, s_valid_i);
      check("load_addr", mem_addr_o, s_valid_i ? k : 0);
      check("load_wdata", mem_wdata_o, s_valid_i ? words[k] : 0);
      if (s_valid_i) begin
        ref_mem[k] = words[k];
        k++;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      cyc++;
    end
    s_valid_i = 1'b1;
`ifdef IMEM_BOOT_LOADER_NOP_FILL_EN
    for (int a = n; a < DEPTH; a++) begin
      #1;
      check("fill_s_ready", s_ready_o, 0);
      check("fill_we", mem_we_o, 1);
      check("fill_addr", mem_addr_o, a);
      check("fill_wdata", mem_wdata_o, NOP);
      check("fill_core_rst_n", core_rst_n_o, 0);
      ref_mem[a] = NOP;
      @(posedge clk); #1;
    end
`endif
    #1;
    s_valid_i = 1'b0;
    check("run_core_rst_n", core_rst_n_o, 1);
    check("run_done", done_o, 1);
    check("run_busy", busy_o, 0);
    check("run_s_ready", s_ready_o, 0);
    check("run_we", mem_we_o, 0);
    for (int a = 0; a < DEPTH; a++) check($sformatf("mem[%0d]", a), dut_mem[a], ref_mem[a]);
  endtask

  task automatic fill_random_words();
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    s_valid_i    = 1'b1;
    fetch_addr_i = 32'h8;
    #1;
    check("idle_s_ready", s_ready_o, 0);
    check("idle_we", mem_we_o, 0);
    check("idle_addr", mem_addr_o, 0);
    check("idle_core_rst_n", core_rst_n_o, 0);
    s_valid_i = 1'b0;

    reject(0, 0);
    reject(17, 0);

    words[0] = 32'h00100093;
    words[1] = 32'h00100313;
    words[2] = 32'h0060A023;
    words[3] = 32'h00000013;
    load(4, 0, -1, 0);

    fetch_addr_i = 32'h8;
    #1 check("fetch_0x8", mem_addr_o, 2);
    fetch_addr_i = 32'h44;
    #1 check("fetch_0x44", mem_addr_o, 1);
    for (int i = 0; i < 4; i++) begin
      fetch_addr_i = $urandom;
      #1 check("fetch_rand", mem_addr_o, (fetch_addr_i / 4) % DEPTH);
    end

    reject(0, 1);
    reject(17, 1);

    fill_random_words();
    load(7, 40, -1, 0);

    fill_random_words();
    load(5, 0, 2, 0);
    fill_random_words();
    load(5, 0, -1, 0);

    fill_random_words();
    load(3, 30, -1, 1);

    for (int i = 0; i < 3; i++) begin
      fill_random_words();
      load($urandom_range(1, DEPTH), 30, -1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
